dla_result_drain: RTL and testbench

- Result-side counterpart to the operand feed of dla_top.
- Tracks each operand set issued into the dot-product core and captures result_top exactly LAT cycles after issue.
- Scales each captured result by an arithmetic right shift, saturates it to a 16-bit signed word, and buffers it in a FIFO.
- Drains the buffer over a valid/ready stream toward writeback.
- Credit logic throttles issue so that no result is ever dropped.

---
 rtl/dla_result_drain.sv | 154 +++++++++++++++
 tb/tb_dla_result_drain.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_result_drain.sv
// dla_result_drain
//   Result-side drain for the dla_top dot-product core. Every accepted
//   operand set is tracked through a LAT-deep delay line. When it emerges,
//   result_top is scaled by an arithmetic right shift, saturated to OUT_W
//   bits and pushed into a FIFO. The FIFO drains over a valid/ready stream.
//   A credit counter holds back issue, so a result is never dropped.
//
//   Optional build macro: DLA_DRAIN_ROUND_EN
//     When defined and SHIFT>0, round half up before the shift.
//     When undefined, the shift truncates.
//
// Ports
//   dla_core_clk   in   core clock, rising edge
//   dla_core_rstn  in   synchronous active-low reset
//   flush          in   synchronous clear of tracker, FIFO and credits
//   issue_valid    in   operand set presented to the core
//   issue_ready    out  result slot available (registered decode)
//   result_top     in   RES_W-bit signed dot-product result
//   out_data       out  head-of-FIFO word (first-word-fall-through)
//   out_valid      out  FIFO non-empty
//   out_ready      in   consumer accepts out_data
//   count          out  words currently held in the FIFO
//   sat_flag       out  sticky saturation indicator
//   sat_clr        in   clears sat_flag (a set in the same cycle wins)
module dla_result_drain #(
    parameter int RES_W = 35,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8,
    parameter int LAT   = 3,
    parameter int SHIFT = 0
) (
    input  logic                     dla_core_clk,
    input  logic                     dla_core_rstn,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [RES_W-1:0]         result_top,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef DLA_DRAIN_ROUND_EN
    // Half of one LSB after the shift; this is zero when SHIFT=0.
    localparam logic signed [RES_W:0] RND = ((RES_W+1)'(1) << SHIFT) >> 1;
`else
    localparam logic signed [RES_W:0] RND = '0;
`endif

    localparam logic signed [RES_W:0] SAT_MAX = {{(RES_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;

    logic [LAT-1:0]   trk_q;
    logic [LAT-1:0]   trk_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    resv_q;
    logic             sat_q;

    logic             accept;
    logic             pop;
    logic             cap;
    logic             push;
    logic signed [RES_W:0] ext;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] shf;
    logic             sat_hi;
    logic             sat_lo;
    logic [OUT_W-1:0] word;

    assign issue_ready = (resv_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    // Gated so the port reads zero while the FIFO is empty, including just after reset.
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign sat_flag    = sat_q;

    assign accept = issue_valid & issue_ready;
    assign pop    = out_valid & out_ready;
    assign cap    = trk_q[LAT-1];
    assign push   = cap & ~flush & dla_core_rstn;

    // Shift the accept bit in at the bottom. The top bit drops off as it is consumed.
    assign trk_d = LAT'({trk_q, accept});

    // Extend by one bit so that adding the rounding constant cannot overflow.
    assign ext    = {result_top[RES_W-1], result_top};
    assign rnd    = ext + RND;
    assign shf    = rnd >>> SHIFT;
    assign sat_hi = (shf > SAT_MAX);
    assign sat_lo = (shf < SAT_MIN);
    assign word   = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                    sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                             shf[OUT_W-1:0];

    always_ff @(posedge dla_core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    always_ff @(posedge dla_core_clk) begin
        if (!dla_core_rstn) begin
            trk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            resv_q   <= '0;
            sat_q    <= 1'b0;
        end else if (flush) begin
            // Any accept, capture or pop in this cycle is discarded.
            trk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            resv_q   <= '0;
            if (sat_clr) begin
                sat_q <= 1'b0;
            end
        end else begin
            trk_q <= trk_d;
            if (cap) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({cap, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({accept, pop})
                2'b10:   resv_q <= resv_q + 1'b1;
                2'b01:   resv_q <= resv_q - 1'b1;
                default: resv_q <= resv_q;
            endcase
            if (cap && (sat_hi || sat_lo)) begin
                sat_q <= 1'b1;
            end else if (sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dla_result_drain.sv
module tb_dla_result_drain;

    localparam int RES_W = 35;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

`ifdef DLA_DRAIN_ROUND_EN
    localparam logic [15:0] EXP22_S2 = 16'h0006;
`else
    localparam logic [15:0] EXP22_S2 = 16'h0005;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn;
    logic             flush;
    logic             issue_valid;
    logic             out_ready;
    logic             sat_clr;
    logic [RES_W-1:0] result_top;

    logic             issue_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic [3:0]       count;
    logic             sat_flag;

    logic             issue_ready2;
    logic [OUT_W-1:0] out_data2;
    logic             out_valid2;
    logic [3:0]       count2;
    logic             sat_flag2;

    dla_result_drain #(.RES_W(RES_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .SHIFT(0)) dut (
        .dla_core_clk (clk),
        .dla_core_rstn(rstn),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .result_top   (result_top),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .sat_flag     (sat_flag),
        .sat_clr      (sat_clr)
    );

    // Same stimulus, scaled by 4; it follows the same handshake as dut.
    dla_result_drain #(.RES_W(RES_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .SHIFT(2)) dut_s2 (
        .dla_core_clk (clk),
        .dla_core_rstn(rstn),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready2),
        .result_top   (result_top),
        .out_data     (out_data2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .count        (count2),
        .sat_flag     (sat_flag2),
        .sat_clr      (sat_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: issue cycles still in flight, and the words expected from each FIFO.
    int          cyc = 0;
    int          pend[$];
    logic [15:0] q0[$];
    logic [15:0] q2[$];
    bit          sat0 = 1'b0;
    int          obs_acc = 0;

    function automatic logic [15:0] mword(input logic [RES_W-1:0] r, input int sh, output bit sat);
        longint v;
        longint s;
        v = longint'($signed(r));
`ifdef DLA_DRAIN_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        s = v >>> sh;
        sat = 1'b0;
        if (s > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end
        if (s < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return s[15:0];
    endfunction

    function automatic logic [RES_W-1:0] rnd_res();
        logic [RES_W-1:0] r;
        case ($urandom_range(0, 3))
            0:       r = RES_W'({$urandom(), $urandom()});
            1:       r = RES_W'($urandom_range(0, 140000));
            2: begin
                r = RES_W'($urandom_range(0, 140000));
                r = -r;
            end
            default: r = RES_W'($urandom_range(0, 200));
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, advance the model using the
    // inputs applied in this cycle, then move to just after the rising edge.
    task automatic step();
        bit          acc;
        bit          pp;
        bit          capd;
        bit          s0;
        bit          s2;
        int          resv;
        logic [15:0] w;
        @(negedge clk);
        resv = pend.size() + q0.size();
        chk("issue_ready", issue_ready, resv != DEPTH);
        chk("out_valid", out_valid, q0.size() != 0);
        chk("count", count, q0.size());
        chk("sat_flag", sat_flag, sat0);
        if (q0.size() != 0) begin
            chk("out_data", out_data, q0[0]);
            chk("out_data_s2", out_data2, q2[0]);
        end
        chk("count_le_depth", count <= DEPTH, 1'b1);
        if (rstn && issue_valid && issue_ready) obs_acc++;
        if (!rstn) begin
            pend.delete(); q0.delete(); q2.delete();
            sat0 = 1'b0;
        end else if (flush) begin
            pend.delete(); q0.delete(); q2.delete();
            if (sat_clr) sat0 = 1'b0;
        end else begin
            acc  = issue_valid && (resv != DEPTH);
            pp   = out_ready && (q0.size() != 0);
            capd = (pend.size() != 0) && (pend[0] + LAT == cyc);
            if (pp) begin
                void'(q0.pop_front());
                void'(q2.pop_front());
            end
            s0 = 1'b0;
            if (capd) begin
                void'(pend.pop_front());
                w = mword(result_top, 0, s0);
                q0.push_back(w);
                w = mword(result_top, 2, s2);
                q2.push_back(w);
            end
            if (capd && s0) sat0 = 1'b1;
            else if (sat_clr) sat0 = 1'b0;
            if (acc) pend.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rstn        = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b1;
        out_ready   = 1'b0;
        sat_clr     = 1'b0;
        result_top  = '0;
        @(posedge clk);
        #1;

        // Reset held with issue_valid high
        step();
        step();
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_issue_ready", issue_ready, 1'b1);
        rstn        = 1'b1;
        issue_valid = 1'b0;
        repeat (5) step();
        chk("rst_no_push", count, 0);

        // Single result with exact latency; the SHIFT=2 instance shows rounding
        result_top  = 35'd20;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        step();
        chk("lat_not_early", out_valid, 1'b0);
        step();
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 16'h0014);
        chk("single_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_popped", count, 0);

        result_top  = 35'd22;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        repeat (3) step();
        chk("r22_s0", out_data, 16'h0016);
        chk("r22_s2", out_data2, EXP22_S2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Saturation and sticky flag
        result_top  = 35'h0_0001_0000;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        repeat (3) step();
        chk("sat_pos_data", out_data, 16'h7FFF);
        chk("sat_pos_flag", sat_flag, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready   = 1'b0;
        result_top  = 35'h7_FFFF_0000;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        repeat (3) step();
        chk("sat_neg_data", out_data, 16'h8000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        sat_clr   = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_cleared", sat_flag, 1'b0);

        // Backpressure: results 1..8 are captured in order with no consumer
        obs_acc     = 0;
        issue_valid = 1'b1;
        base        = cyc;
        for (int i = 0; i < 14; i++) begin
            result_top = RES_W'(cyc - base - LAT + 1);
            step();
        end
        chk("bp_accepts", obs_acc, 8);
        chk("bp_ready_low", issue_ready, 1'b0);
        chk("bp_count_full", count, 8);
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        chk("bp_first", out_data, 16'd1);
        step();
        chk("bp_ready_back", issue_ready, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            chk("bp_order", out_data, 16'(k));
            step();
        end
        out_ready = 1'b0;
        chk("bp_drained", count, 0);

        // Simultaneous accept and pop with 7 reserved and 4 stored
        issue_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            result_top = rnd_res();
            step();
        end
        chk("ap_count_before", count, 4);
        out_ready  = 1'b1;
        result_top = rnd_res();
        step();
        chk("ap_count_after", count, 4);
        chk("ap_ready_after", issue_ready, 1'b1);
        issue_valid = 1'b0;
        repeat (8) begin
            result_top = rnd_res();
            step();
        end
        chk("ap_drained", count, 0);

        // Continuous streaming, one issue per cycle
        issue_valid = 1'b1;
        out_ready   = 1'b1;
        repeat (30) begin
            result_top = rnd_res();
            step();
            chk("stream_no_stall", issue_ready, 1'b1);
        end
        issue_valid = 1'b0;
        repeat (6) step();

        // Flush with two results in flight and three stored
        result_top  = 35'h0_0001_0000;
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        repeat (5) step();
        issue_valid = 1'b0;
        step();
        chk("fl_stored", count, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ready", issue_ready, 1'b1);
        chk("fl_sat_kept", sat_flag, 1'b1);
        repeat (6) step();
        chk("fl_no_ghost", count, 0);

        // Randomized traffic with occasional flush and sat_clr
        repeat (300) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            sat_clr     = ($urandom_range(0, 15) == 0);
            flush       = ($urandom_range(0, 59) == 0);
            result_top  = rnd_res();
            step();
        end
        issue_valid = 1'b0;
        flush       = 1'b0;
        sat_clr     = 1'b0;
        out_ready   = 1'b1;
        repeat (12) step();
        chk("final_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
